// File: rtl/pulse_sync_sched.sv
// pulse_sync_sched: shares one toggle-based pulse_sync crossing among NUM_REQ
// event requesters. Each requester has a saturating pending counter. A
// round-robin arbiter selects the next requester, and the block issues one
// spaced pulse at a time together with the granted requester id.
// Optional feature: define PULSE_SYNC_SCHED_ACK_EN to add ack_pulse and the
// WAIT_ACK state, which limits the block to one outstanding event at a time.
module pulse_sync_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned GAP     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic [NUM_REQ-1:0] ovf_clr,
`ifdef PULSE_SYNC_SCHED_ACK_EN
  input  logic               ack_pulse,
`endif
  output logic               sync_pulse,
  output logic [ID_W-1:0]    sync_id,
  output logic [NUM_REQ-1:0] ovf,
  output logic               busy
);

  localparam int unsigned GC_W = (GAP > 2) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP
`ifdef PULSE_SYNC_SCHED_ACK_EN
    , ST_WAIT_ACK
`endif
  } state_t;

  state_t                          state;
  logic [GC_W-1:0]                 gap_cnt;
  logic [ID_W-1:0]                 rr_ptr;
  logic [NUM_REQ-1:0][CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0]              pend;
  logic [ID_W-1:0]                 winner;
  logic [ID_W-1:0]                 next_ptr;
  logic                            found;
  logic                            issue;
  int unsigned                     win_idx;
`ifdef PULSE_SYNC_SCHED_ACK_EN
  logic                            ack_seen;
`endif

  // Round-robin search: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    win_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      win_idx = 32'(rr_ptr) + k;
      if (win_idx >= NUM_REQ) win_idx = win_idx - NUM_REQ;
      if (!found && pend[ID_W'(win_idx)]) begin
        found  = 1'b1;
        winner = ID_W'(win_idx);
      end
    end
  end

  assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign issue    = (state == ST_IDLE) && en && (|pend);
  assign busy     = (state != ST_IDLE) || (|pend);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic inc;
    logic dec;
    logic sat;

    assign inc     = req_pulse[g];
    assign dec     = issue && (winner == ID_W'(g));
    assign sat     = &cnt[g];
    assign pend[g] = |cnt[g];

    // Pending counter with saturation; a dropped event sets the sticky flag,
    // and a set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt[g] <= '0;
        ovf[g] <= 1'b0;
      end else begin
        if (inc && !dec && !sat) cnt[g] <= cnt[g] + 1'b1;
        else if (dec && !inc)    cnt[g] <= cnt[g] - 1'b1;
        if (inc && !dec && sat)  ovf[g] <= 1'b1;
        else if (ovf_clr[g])     ovf[g] <= 1'b0;
      end
    end
  end

  // Issue FSM: one registered pulse, then GAP-1 cycles of spacing before IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sync_pulse <= 1'b0;
      sync_id    <= '0;
      rr_ptr     <= '0;
      gap_cnt    <= '0;
`ifdef PULSE_SYNC_SCHED_ACK_EN
      ack_seen   <= 1'b0;
`endif
    end else begin
      sync_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            sync_pulse <= 1'b1;
            sync_id    <= winner;
            rr_ptr     <= next_ptr;
            gap_cnt    <= GC_W'(GAP - 2);
            state      <= ST_GAP;
`ifdef PULSE_SYNC_SCHED_ACK_EN
            ack_seen   <= 1'b0;
`endif
          end
        end
        ST_GAP: begin
`ifdef PULSE_SYNC_SCHED_ACK_EN
          if (ack_pulse) ack_seen <= 1'b1;
`endif
          if (gap_cnt == '0) begin
`ifdef PULSE_SYNC_SCHED_ACK_EN
            // An ack already seen during GAP is consumed here, so spacing
            // stays exactly GAP cycles instead of passing through WAIT_ACK.
            state <= (ack_seen || ack_pulse) ? ST_IDLE : ST_WAIT_ACK;
`else
            state <= ST_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`ifdef PULSE_SYNC_SCHED_ACK_EN
        ST_WAIT_ACK: begin
          if (ack_pulse) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
